adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Envelope generator directly upstream of the Synth voice.
- Turns a gate (button or sequencer) into a 10-bit amplitude that drives Synth amp_in, replacing the constant 1023.
- Classic ADSR: linear segments, updated on a prescaled control tick derived from the 48 MHz HFOSC clock.
- Gate is synchronised internally, so a raw button can drive it directly.

Parameters:
- CLKSPEED, 48_000_000, system clock frequency in Hz.
- TICK_HZ, 48_000, envelope update rate in Hz; DIV = CLKSPEED/TICK_HZ, must be an integer ≥ 2.
- WIDTH, 10, amplitude output width.
- FRAC, 8, fractional accumulator bits; ACC_W = WIDTH+FRAC (18), ACC_MAX = 2^ACC_W−1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gate  in  1  asynchronous note gate; high = key held.
- attack_step  in  16  accumulator increment per tick in ATTACK.
- decay_step  in  16  decrement per tick in DECAY.
- sustain_level  in  WIDTH  sustain amplitude; target = sustain_level<<FRAC.
- release_step  in  16  decrement per tick in RELEASE.
- amp_out  out  WIDTH  envelope amplitude = acc[ACC_W-1:FRAC], registered.
- stage  out  3  current state encoding, for LED display.
- active  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset, synchronous and active-high:
  - state = IDLE, acc = 0, prescaler = 0, sync/edge flops = 0.
  - amp_out = 0, stage = IDLE, active = 0.
- Gate path:
  - Two-flop synchroniser, then a gate_prev register.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - State changes no later than 3 clk edges after gate first sampled at a new level.
- Prescaler:
  - Counts 0..DIV-1.
  - tick is high for one clk when count == DIV-1, then the count wraps to 0.
  - Free-running; not affected by gate.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Edge transitions, evaluated every clk:
  - rise → ATTACK from any state, including ATTACK. Retrigger keeps the current acc and does not restart from 0.
  - fall → RELEASE from ATTACK, DECAY or SUSTAIN. fall in IDLE or RELEASE: no effect.
  - On a cycle with rise or fall, acc is not updated even if tick is high; that tick is skipped.
- Tick-driven updates (tick high, no edge that cycle):
  - ATTACK: acc = min(acc+attack_step, ACC_MAX). When the result equals ACC_MAX → DECAY. attack_step = 0 stalls in ATTACK.
  - DECAY: target = sustain_level<<FRAC. If acc − decay_step ≤ target (including underflow), acc = target → SUSTAIN; otherwise acc −= decay_step. If acc < target on entry, for example after sustain_level rises, acc = target → SUSTAIN.
  - SUSTAIN: acc = sustain_level<<FRAC every tick, so live changes to sustain_level are followed at tick rate.
  - RELEASE: if acc ≤ release_step, acc = 0 → IDLE; otherwise acc −= release_step.
  - IDLE: acc held at 0.
- Arithmetic:
  - Attack sum computed at ACC_W+1 bits to detect overflow.
  - Decay/release compared before subtracting; the result never wraps.
- Outputs:
  - amp_out, stage and active are registered and reflect acc/state one clk after the update edge.
  - Step inputs and sustain_level are sampled only on tick cycles.
- Reset mid-operation: immediate return to the reset values on the next edge; no release tail.

Decomposition:
- Package adsr_pkg:
  - State localparams (IDLE..RELEASE, 3-bit).
  - FRAC default.
  - ACC_W/ACC_MAX derivation function.
- One sub-module: tick_prescaler (params CLKSPEED, TICK_HZ; ports clk, reset, tick).
  - Reused later for LFO and sequencer timing.
- The FSM and accumulator stay in adsr_envelope.

Test Plan:
All cases use CLKSPEED=1000, TICK_HZ=100 (DIV=10).
- Reset: reset held 3 clks mid-ATTACK → next edge amp_out=0, stage=0, active=0; prescaler restarts (first tick 10 clks after reset release).
- Attack: attack_step=0x4000, gate high → amp_out steps 64,128,…,960 on successive ticks; 16th tick saturates at 1023 and stage goes to 2.
- Decay/sustain: decay_step=0x1000, sustain_level=512 → amp_out falls by 16 per tick; after 32 decay ticks amp_out=512, stage=3. Changing sustain_level to 300 → amp_out=300 on the next tick.
- Release: from SUSTAIN at 512, release_step=0x8000, gate low → amp_out 384,256,128,0 over 4 ticks, then stage=0, active=0.
- Retrigger: gate low→high while in RELEASE at amp 256 → ATTACK resumes from 256 (next tick 320), not from 0.
- Edge/tick collision: gate rise timed so the edge lands on a tick cycle → stage=1 and acc unchanged on that tick; first increment on the following tick.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types and width helpers for the ADSR envelope generator.
package adsr_pkg;

    localparam int unsigned FRAC_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned frac);
        return width + frac;
    endfunction

    function automatic int unsigned acc_max(input int unsigned acc_w);
        return (32'd1 << acc_w) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_tick_prescaler.sv
// Free-running divider producing a one-clock tick every CLKSPEED/TICK_HZ clocks.
module tick_prescaler #(
    parameter int unsigned CLKSPEED = 48_000_000,
    parameter int unsigned TICK_HZ  = 48_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV = CLKSPEED / TICK_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// Linear ADSR envelope: synchronised gate edges drive the FSM, a prescaled
// tick advances a fixed-point accumulator whose integer part is the amplitude.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned CLKSPEED = 48_000_000,
    parameter int unsigned TICK_HZ  = 48_000,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned FRAC     = FRAC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gate,
    input  logic [15:0]      attack_step,
    input  logic [15:0]      decay_step,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [15:0]      release_step,
    output logic [WIDTH-1:0] amp_out,
    output logic [2:0]       stage,
    output logic             active
);

    localparam int unsigned ACC_W = acc_width(WIDTH, FRAC);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));

    logic             tick;
    logic             sync1, sync2, gate_prev;
    logic             rise, fall;
    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [ACC_W-1:0] target, atk_inc, dec_dec, rel_dec;
    logic [ACC_W:0]   atk_sum;
    logic [WIDTH-1:0] amp_d;
    logic [2:0]       stage_d;
    logic             active_d;

    tick_prescaler #(
        .CLKSPEED(CLKSPEED),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            gate_prev <= 1'b0;
        end else begin
            sync1     <= gate;
            sync2     <= sync1;
            gate_prev <= sync2;
        end
    end

    assign rise = sync2 & ~gate_prev;
    assign fall = ~sync2 & gate_prev;

    assign target  = {sustain_level, {FRAC{1'b0}}};
    assign atk_inc = ACC_W'(attack_step);
    assign dec_dec = ACC_W'(decay_step);
    assign rel_dec = ACC_W'(release_step);
    assign atk_sum = {1'b0, acc} + {1'b0, atk_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
        end
    end

    // Any gate edge takes priority and swallows a coincident tick.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        if (rise) begin
            state_n = ATTACK;
        end else if (fall) begin
            if (state inside {ATTACK, DECAY, SUSTAIN}) begin
                state_n = RELEASE;
            end
        end else if (tick) begin
            unique case (state)
                IDLE: acc_n = '0;
                ATTACK: begin
                    if (atk_sum >= {1'b0, ACC_MAX}) begin
                        acc_n   = ACC_MAX;
                        state_n = DECAY;
                    end else begin
                        acc_n = atk_sum[ACC_W-1:0];
                    end
                end
                DECAY: begin
                    if ((acc <= target) || ((acc - target) <= dec_dec)) begin
                        acc_n   = target;
                        state_n = SUSTAIN;
                    end else begin
                        acc_n = acc - dec_dec;
                    end
                end
                SUSTAIN: acc_n = target;
                RELEASE: begin
                    if (acc <= rel_dec) begin
                        acc_n   = '0;
                        state_n = IDLE;
                    end else begin
                        acc_n = acc - rel_dec;
                    end
                end
                default: begin
                    acc_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        amp_d    = acc[ACC_W-1:FRAC];
        stage_d  = state;
        active_d = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            amp_out <= '0;
            stage   <= 3'd0;
            active  <= 1'b0;
        end else begin
            amp_out <= amp_d;
            stage   <= stage_d;
            active  <= active_d;
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope with a 10-clock tick period.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [15:0] attack_step, decay_step, release_step;
    logic [9:0]  sustain_level;
    logic [9:0]  amp_out;
    logic [2:0]  stage;
    logic        active;

    int compared   = 0;
    int mismatched = 0;
    int unsigned n = 0;  // edges since the last reset edge

    typedef struct {
        logic       g;
        logic [9:0] sus;
        logic [9:0] amp;
        logic [2:0] stg;
        logic       act;
        string      name;
    } vec_t;

    typedef struct {
        logic [9:0] amp;
        logic [2:0] stg;
        logic       act;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    adsr_envelope #(
        .CLKSPEED(1000),
        .TICK_HZ (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .gate         (gate),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .sustain_level(sustain_level),
        .release_step (release_step),
        .amp_out      (amp_out),
        .stage        (stage),
        .active       (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic add_vec(input logic g, input logic [9:0] sus, input logic [9:0] amp,
                           input logic [2:0] stg, input logic act, input string name);
        vec_t v;
        v.g = g; v.sus = sus; v.amp = amp; v.stg = stg; v.act = act; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic expect_out(input string name, input logic [9:0] amp,
                              input logic [2:0] stg, input logic act);
        exp_t e;
        e.amp = amp; e.stg = stg; e.act = act; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        compared++;
        if (amp_out !== e.amp) begin
            mismatched++;
            $display("FAIL %s amp_out: got %0d required %0d", e.name, amp_out, e.amp);
        end
        compared++;
        if (stage !== e.stg) begin
            mismatched++;
            $display("FAIL %s stage: got %0d required %0d", e.name, stage, e.stg);
        end
        compared++;
        if (active !== e.act) begin
            mismatched++;
            $display("FAIL %s active: got %0b required %0b", e.name, active, e.act);
        end
    endtask

    // Advance to just after the edge where a tick's result appears on the outputs.
    task automatic wait_out();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (n % 10 == 1) return;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_out: got no output edge in 20 clks, required within 10");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 1; k <= 15; k++) add_vec(1'b1, 10'd512, 10'(64 * k), 3'd1, 1'b1, "attack");
        add_vec(1'b1, 10'd512, 10'd1023, 3'd2, 1'b1, "attack_sat");
        for (int k = 1; k <= 31; k++) add_vec(1'b1, 10'd512, 10'(1023 - 16 * k), 3'd2, 1'b1, "decay");
        add_vec(1'b1, 10'd512, 10'd512, 3'd3, 1'b1, "decay_to_sus");
        add_vec(1'b1, 10'd512, 10'd512, 3'd3, 1'b1, "sus_hold");
        add_vec(1'b1, 10'd300, 10'd300, 3'd3, 1'b1, "sus_live");
        add_vec(1'b1, 10'd512, 10'd512, 3'd3, 1'b1, "sus_back");
        add_vec(1'b0, 10'd512, 10'd384, 3'd4, 1'b1, "rel1");
        add_vec(1'b0, 10'd512, 10'd256, 3'd4, 1'b1, "rel2");
        add_vec(1'b1, 10'd512, 10'd320, 3'd1, 1'b1, "retrig");
        add_vec(1'b1, 10'd512, 10'd384, 3'd1, 1'b1, "retrig2");
        add_vec(1'b0, 10'd512, 10'd256, 3'd4, 1'b1, "rel_a");
        add_vec(1'b0, 10'd512, 10'd128, 3'd4, 1'b1, "rel_b");
        add_vec(1'b0, 10'd512, 10'd0,   3'd0, 1'b0, "rel_idle");
        add_vec(1'b0, 10'd512, 10'd0,   3'd0, 1'b0, "idle_hold");

        reset         = 1'b1;
        gate          = 1'b0;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        release_step  = 16'h8000;
        sustain_level = 10'd512;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset_state", 10'd0, 3'd0, 1'b0);
        check_out();
        reset = 1'b0;
        wait_out();

        foreach (vecs[i]) begin
            gate          = vecs[i].g;
            sustain_level = vecs[i].sus;
            expect_out(vecs[i].name, vecs[i].amp, vecs[i].stg, vecs[i].act);
            wait_out();
            check_out();
        end

        // Rise lands on the tick edge: state moves, accumulator stays put.
        repeat (6) @(posedge clk);
        #1;
        gate = 1'b1;
        expect_out("collide_skip", 10'd0, 3'd1, 1'b1);
        wait_out();
        check_out();
        expect_out("collide_next", 10'd64, 3'd1, 1'b1);
        wait_out();
        check_out();

        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_out("reset_mid", 10'd0, 3'd0, 1'b0);
        check_out();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        expect_out("post_rst_pre_tick", 10'd0, 3'd1, 1'b1);
        check_out();
        @(posedge clk);
        #1;
        expect_out("post_rst_first_tick", 10'd64, 3'd1, 1'b1);
        check_out();

        attack_step = 16'h0000;
        expect_out("attack_stall", 10'd64, 3'd1, 1'b1);
        wait_out();
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
